// File: rtl/mux32_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux32_rr_arbiter
// Brief    : Round-robin arbiter for four requesters sharing one datapath,
//            with a registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module mux32_rr_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [3:0]        last,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic              ready,
    output logic [3:0]        gnt,
    output logic [1:0]        select,
    output logic [3:0]        ack,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;
    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [1:0]        r_ptr;
    logic [7:0]        r_beat_cnt;
    logic [3:0]        r_gnt;
    logic [1:0]        r_select;
    logic [3:0]        r_ack;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;

    logic [3:0]        w_gnt_nxt;
    logic [1:0]        w_select_nxt;
    logic [1:0]        w_ptr_nxt;
    logic [7:0]        w_beat_nxt;
    logic [3:0]        w_ack_nxt;
    logic [DATA_W-1:0] w_out_nxt;
    logic              w_out_valid_nxt;

    logic              w_pick_vld;
    logic [1:0]        w_pick_idx;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_req;
    logic              w_sel_last;
    logic [7:0]        w_beat_inc;
    logic              w_cap;
    logic              w_release;

    // Scan starts just after the last granted index, so the previous owner
    // is considered last.
    always_comb begin
        logic [1:0] v_idx;
        w_pick_vld = 1'b0;
        w_pick_idx = 2'd0;
        v_idx      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_ptr + 2'(k);
            if (!w_pick_vld && req[v_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = v_idx;
            end
        end
    end

    always_comb begin
        case (r_select)
            2'd0:    w_sel_data = in1;
            2'd1:    w_sel_data = in2;
            2'd2:    w_sel_data = in3;
            default: w_sel_data = in4;
        endcase
    end

    assign w_sel_req  = req[r_select];
    assign w_sel_last = last[r_select];
    assign w_beat_inc = r_beat_cnt + 8'd1;

    // A capture needs room in the output stage: empty, or draining this edge.
    assign w_cap     = (r_state == c_st_grant) && w_sel_req && (!r_out_valid || ready);
    assign w_release = (r_state == c_st_grant) &&
                       (!w_sel_req || (w_cap && (w_sel_last || (w_beat_inc == c_max_hold))));

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_ptr       <= 2'd3;
            r_beat_cnt  <= 8'd0;
            r_gnt       <= 4'd0;
            r_select    <= 2'd0;
            r_ack       <= 4'd0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_gnt       <= w_gnt_nxt;
            r_select    <= w_select_nxt;
            r_ack       <= w_ack_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_pick_vld) w_state_nxt = c_st_grant;
            c_st_grant: if (w_release)  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_gnt_nxt       = r_gnt;
        w_select_nxt    = r_select;
        w_ptr_nxt       = r_ptr;
        w_beat_nxt      = r_beat_cnt;
        w_ack_nxt       = 4'd0;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            c_st_idle: begin
                if (w_pick_vld) begin
                    w_gnt_nxt    = 4'b0001 << w_pick_idx;
                    w_select_nxt = w_pick_idx;
                    w_ptr_nxt    = w_pick_idx;
                    w_beat_nxt   = 8'd0;
                end
            end
            c_st_grant: begin
                if (w_cap) begin
                    w_beat_nxt = w_beat_inc;
                    w_ack_nxt  = 4'b0001 << r_select;
                end
                if (w_release) begin
                    w_gnt_nxt = 4'd0;
                end
            end
            default: w_gnt_nxt = 4'd0;
        endcase
        // Capture wins over drain so a simultaneous accept keeps out_valid high.
        if (w_cap) begin
            w_out_nxt       = w_sel_data;
            w_out_valid_nxt = 1'b1;
        end else if (r_out_valid && ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    assign gnt       = r_gnt;
    assign select    = r_select;
    assign ack       = r_ack;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == c_st_grant);

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_busy_gnt    : assert property (@(posedge clk) disable iff (!rst_n) busy == (gnt != 4'd0));
    a_select_gnt  : assert property (@(posedge clk) disable iff (!rst_n)
                                     (gnt != 4'd0) |-> (gnt == (4'b0001 << select)));

endmodule
`default_nettype wire

// File: tb/tb_mux32_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux32_rr_arbiter
// Brief    : Directed and randomized bench for mux32_rr_arbiter against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux32_rr_arbiter;

    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req;
    logic [3:0]        last;
    logic [DATA_W-1:0] din [4];
    logic              ready;
    logic [3:0]        gnt;
    logic [1:0]        select;
    logic [3:0]        ack;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner is -1 when nothing is granted.
    int          m_owner;
    int          m_ptr;
    int          m_beats;
    logic [31:0] m_out;
    bit          m_valid;
    logic [3:0]  m_ack;

    mux32_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .in1       (din[0]),
        .in2       (din[1]),
        .in3       (din[2]),
        .in4       (din[3]),
        .ready     (ready),
        .gnt       (gnt),
        .select    (select),
        .ack       (ack),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_beats = 0;
        m_out   = '0;
        m_valid = 1'b0;
        m_ack   = 4'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_gnt"},   32'(gnt),       32'd0);
        check_eq({tag, "_ack"},   32'(ack),       32'd0);
        check_eq({tag, "_out"},   out,            32'd0);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    // Advance one clock: predict from the current inputs, then compare.
    task automatic step();
        int          n_owner, n_ptr, n_beats, idx;
        logic [31:0] n_out;
        bit          n_valid, cap;
        logic [3:0]  n_ack;
        n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats;
        n_out = m_out; n_valid = m_valid; n_ack = 4'd0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (n_owner < 0 && req[idx]) begin
                    n_owner = idx; n_ptr = idx; n_beats = 0;
                end
            end
            if (m_valid && ready) n_valid = 1'b0;
        end else begin
            cap = req[m_owner] && (!m_valid || ready);
            if (cap) begin
                n_out = din[m_owner];
                n_valid = 1'b1;
                n_ack[m_owner] = 1'b1;
                n_beats = m_beats + 1;
                if (last[m_owner] || n_beats == MAX_HOLD) n_owner = -1;
            end else begin
                if (m_valid && ready) n_valid = 1'b0;
                if (!req[m_owner]) n_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats;
        m_out = n_out; m_valid = n_valid; m_ack = n_ack;
        check_eq("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        if (m_owner >= 0) check_eq("select", 32'(select), 32'(m_owner));
        check_eq("ack", 32'(ack), 32'(m_ack));
        check_eq("out", out, m_out);
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int          acks2;
        int          gq[$];
        int          gi;
        logic [3:0]  prev_gnt;
        logic [31:0] held;

        rst_n = 1'b0; req = 4'd0; last = 4'd0; ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        model_reset();
        #12;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single word from requester 0
        req = 4'b0001; din[0] = 32'hAAAA0001; last = 4'b0001; ready = 1'b1;
        step();
        check_eq("t1_gnt", 32'(gnt), 32'h1);
        step();
        check_eq("t1_ack", 32'(ack), 32'h1);
        check_eq("t1_out", out, 32'hAAAA0001);
        check_eq("t1_gnt_rel", 32'(gnt), 32'h0);
        req = 4'd0;
        step();

        // Full contention, single-beat bursts
        do_reset();
        req = 4'b1111; last = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = $urandom;
        prev_gnt = 4'd0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt != 4'd0 && prev_gnt == 4'd0) begin
                gi = 0;
                for (int b = 0; b < 4; b++) if (gnt[b]) gi = b;
                gq.push_back(gi);
            end
            prev_gnt = gnt;
            for (int i = 0; i < 4; i++) if (m_ack[i]) din[i] = $urandom;
        end
        check_eq("t2_ngrants", 32'(gq.size()), 32'd5);
        foreach (gq[k]) check_eq("t2_order", 32'(gq[k]), 32'(k % 4));

        // Hold limit on requester 2, then rotation
        do_reset();
        req = 4'b0100; last = 4'b0000; ready = 1'b1; din[2] = 32'h22220000;
        acks2 = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            if (ack[2]) acks2++;
            if (m_ack[2]) din[2] = din[2] + 32'd1;
        end
        check_eq("t3_gnt_rel", 32'(gnt), 32'h0);
        req = 4'b0110; din[1] = 32'h11110000;
        step();
        if (ack[2]) acks2++;
        check_eq("t3_acks", 32'(acks2), 32'd8);
        check_eq("t3_next", 32'(gnt), 32'h2);

        // Backpressure
        step();
        held = out;
        din[1] = 32'h11110001;
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("t4_stable", out, held);
            check_eq("t4_noack", 32'(ack), 32'h0);
        end
        ready = 1'b1;
        step();
        check_eq("t4_resume", 32'(ack), 32'h2);
        check_eq("t4_valid", 32'(out_valid), 32'h1);

        // Drop request mid-burst
        do_reset();
        req = 4'b0001; last = 4'b0000; ready = 1'b1; din[0] = 32'h0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (m_ack[0]) din[0] = din[0] + 32'd1;
        end
        req = 4'b0000;
        step();
        check_eq("t5_noack", 32'(ack), 32'h0);
        check_eq("t5_gnt", 32'(gnt), 32'h0);
        req = 4'b0011; din[1] = 32'h55;
        step();
        check_eq("t5_ptr", 32'(gnt), 32'h2);

        // Asynchronous reset mid-burst
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        req = 4'b1111;
        step();
        check_eq("t6_first", 32'(gnt), 32'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_ack[i] || !req[i]) begin
                    req[i]  = ($urandom_range(0, 3) != 0);
                    din[i]  = $urandom;
                    last[i] = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("rnd_async");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                model_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
